regs_writeback_scoreboard: RTL

- Producer-side counterpart of the ID-stage forwarding/hazard check.
- Records every architectural register write when ID issues it, and retires it when WB commits it.
- Tells ID whether a source register still has an outstanding "late" write. A late write is a load or csr_rwc result known only at WB, so it cannot be forwarded from EX/MEM.
- Sits beside the ID stage; the issue port is driven by ID, the retire port by WB, and flush by the exception/ertn logic.

---
 rtl/regs_writeback_scoreboard_if.sv | 45 ++++
 rtl/regs_writeback_scoreboard.sv | 116 +++++++++++
 2 files changed

// File: rtl/regs_writeback_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : regs_writeback_scoreboard_if
// Purpose  : Issue / ID-read / WB-retire / flush bundle for the writeback
//            scoreboard. The master side is the pipeline (ID, WB, flush
//            logic); the slave side is the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface regs_writeback_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
);
  logic                    flush;
  logic                    issue_valid;
  logic                    issue_we;
  logic [ADDR_W-1:0]       issue_waddr;
  logic                    issue_late;
  logic                    issue_ready;
  logic [ADDR_W-1:0]       id_raddr1;
  logic                    id_rvalid1;
  logic [ADDR_W-1:0]       id_raddr2;
  logic                    id_rvalid2;
  logic                    read_ready;
  logic                    wb_valid;
  logic                    wb_we;
  logic [ADDR_W-1:0]       wb_waddr;
  logic                    wb_late;
  logic [ADDR_W+CNT_W-1:0] inflight_cnt;
  logic                    err_underflow;

  modport master (
    output flush, issue_valid, issue_we, issue_waddr, issue_late,
    output id_raddr1, id_rvalid1, id_raddr2, id_rvalid2,
    output wb_valid, wb_we, wb_waddr, wb_late,
    input  issue_ready, read_ready, inflight_cnt, err_underflow
  );

  modport slave (
    input  flush, issue_valid, issue_we, issue_waddr, issue_late,
    input  id_raddr1, id_rvalid1, id_raddr2, id_rvalid2,
    input  wb_valid, wb_we, wb_waddr, wb_late,
    output issue_ready, read_ready, inflight_cnt, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/regs_writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regs_writeback_scoreboard
// Purpose  : Tracks outstanding GPR writes between ID issue and WB commit and
//            stalls ID while a source register awaits a late (WB-only) result.
// Revision : 1.0 - initial release
// ============================================================================
module regs_writeback_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  regs_writeback_scoreboard_if.slave   sb
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam int               c_tot_w   = ADDR_W + CNT_W;

  logic [CNT_W-1:0]   r_cnt      [REG_NUM];
  logic [CNT_W-1:0]   r_late_cnt [REG_NUM];
  logic [c_tot_w-1:0] r_inflight;
  logic               r_err;

  logic               w_hazard1;
  logic               w_hazard2;
  logic               w_read_ready;
  logic               w_full;
  logic               w_issue_ready;
  logic               w_accept_wr;
  logic               w_retire;
  logic               w_retire_cnt;
  logic               w_underflow;
  logic [REG_NUM-1:0] w_inc;
  logic [REG_NUM-1:0] w_linc;
  logic [REG_NUM-1:0] w_dec;
  logic [REG_NUM-1:0] w_ldec;

  // Hazards look only at registered state; a retire this cycle is not bypassed.
  assign w_hazard1    = sb.id_rvalid1 && (sb.id_raddr1 != '0) && (r_late_cnt[sb.id_raddr1] != '0);
  assign w_hazard2    = sb.id_rvalid2 && (sb.id_raddr2 != '0) && (r_late_cnt[sb.id_raddr2] != '0);
  assign w_read_ready = !w_hazard1 && !w_hazard2;

  // A saturated per-register counter cannot take another in-flight write.
  assign w_full        = sb.issue_we && (sb.issue_waddr != '0) && (r_cnt[sb.issue_waddr] == c_cnt_max);
  assign w_issue_ready = w_read_ready && !sb.flush && !w_full;
  assign w_accept_wr   = sb.issue_valid && w_issue_ready && sb.issue_we && (sb.issue_waddr != '0);

  // Flush discards the retire along with everything else in flight.
  assign w_retire     = !sb.flush && sb.wb_valid && sb.wb_we && (sb.wb_waddr != '0);
  assign w_retire_cnt = w_retire && (r_cnt[sb.wb_waddr] != '0);
  assign w_underflow  = w_retire && ((r_cnt[sb.wb_waddr] == '0) ||
                                     (sb.wb_late && (r_late_cnt[sb.wb_waddr] == '0)));

  assign sb.read_ready    = w_read_ready;
  assign sb.issue_ready   = w_issue_ready;
  assign sb.inflight_cnt  = r_inflight;
  assign sb.err_underflow = r_err;

  // Per-register increment/decrement strobes; a retire on an empty counter is dropped.
  always_comb begin
    w_inc  = '0;
    w_linc = '0;
    w_dec  = '0;
    w_ldec = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      w_inc[i]  = w_accept_wr && (sb.issue_waddr == ADDR_W'(i));
      w_linc[i] = w_inc[i] && sb.issue_late;
      w_dec[i]  = w_retire && (sb.wb_waddr == ADDR_W'(i)) && (r_cnt[i] != '0);
      w_ldec[i] = w_retire && (sb.wb_waddr == ADDR_W'(i)) && sb.wb_late && (r_late_cnt[i] != '0);
    end
  end

  // Per-register counters; flush clears them, register 0 never moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_cnt[i]      <= '0;
        r_late_cnt[i] <= '0;
      end
    end else if (sb.flush) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_cnt[i]      <= '0;
        r_late_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        r_cnt[i]      <= r_cnt[i] + CNT_W'(w_inc[i]) - CNT_W'(w_dec[i]);
        r_late_cnt[i] <= r_late_cnt[i] + CNT_W'(w_linc[i]) - CNT_W'(w_ldec[i]);
      end
    end
  end

  // Running total of in-flight writes, kept equal to the sum of the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (sb.flush) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= r_inflight + c_tot_w'(w_accept_wr) - c_tot_w'(w_retire_cnt);
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_underflow) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
